// File: rtl/add_seq_pkg.sv
// add_seq_pkg: state type, default sizes and slice-count helpers for add_seq
package add_seq_pkg;
   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
   localparam int DEF_WIDTH = 64;
   localparam int DEF_SLICE = 16;
   function automatic int nslice(input int width, input int slice);
      return width / slice;
   endfunction
   function automatic int idx_w(input int width, input int slice);
      return nslice(width, slice) > 1 ? $clog2(nslice(width, slice)) : 1;
   endfunction
endpackage

// File: rtl/add_seq_if.sv
// add_seq_if: operand/result valid-ready bundle for add_seq
interface add_seq_if import add_seq_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
   logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
   logic [WIDTH-1:0] a, b, sum;
   modport master(output in_valid, a, b, cin, sub, out_ready, input in_ready, out_valid, sum, cout);
   modport slave(input in_valid, a, b, cin, sub, out_ready, output in_ready, out_valid, sum, cout);
endinterface

// File: rtl/add_slice.sv
// add_slice: SLICE-bit combinational ripple-carry adder
module add_slice #(parameter int SLICE = 16) (
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   input  logic             ci,
   output logic [SLICE-1:0] s,
   output logic             co
);
   logic [SLICE:0] c;
   always_comb begin
      c = '0;
      s = '0;
      c[0] = ci;
      for (int i = 0; i < SLICE; i++) begin
         s[i] = x[i] ^ y[i] ^ c[i];
         c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
      end
   end
   assign co = c[SLICE];
endmodule

// File: rtl/add_seq.sv
// add_seq: multi-cycle add reusing one SLICE-bit adder per clock; ADD_SEQ_SUB_EN adds a - b support
module add_seq import add_seq_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic       clk,
   input  logic       rst,
   add_seq_if.slave   io,
   output logic       busy
);
   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int IW = idx_w(WIDTH, SLICE);
   state_t state, state_n;
   logic [WIDTH-1:0] a_r, b_r, sum_r, b_eff;
   logic [IW-1:0] idx;
   logic [SLICE-1:0] s;
   logic carry, cout_r, co, cin_eff, last, accept;
`ifdef ADD_SEQ_SUB_EN
   assign b_eff = io.sub ? ~io.b : io.b;
   assign cin_eff = io.sub | io.cin;
`else
   logic unused_sub;
   assign unused_sub = io.sub;
   assign b_eff = io.b;
   assign cin_eff = io.cin;
`endif
   assign last = idx == IW'(NSLICE - 1);
   assign accept = state == IDLE && io.in_valid;
   add_slice #(.SLICE(SLICE)) u_slice (
      .x(a_r[idx*SLICE +: SLICE]),
      .y(b_r[idx*SLICE +: SLICE]),
      .ci(carry),
      .s(s),
      .co(co)
   );
   always_comb begin
      state_n = state;
      state_n = state == IDLE ? (io.in_valid ? CALC : IDLE) :
                state == CALC ? (last ? HOLD : CALC) :
                (io.out_ready ? IDLE : HOLD);
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_n;
   // carry is preloaded with the effective cin so slice 0 needs no special case
   always_ff @(posedge clk)
      if (rst) begin
         a_r <= '0;
         b_r <= '0;
         sum_r <= '0;
         idx <= '0;
         carry <= 1'b0;
         cout_r <= 1'b0;
      end else if (accept) begin
         a_r <= io.a;
         b_r <= b_eff;
         carry <= cin_eff;
         idx <= '0;
      end else if (state == CALC) begin
         sum_r[idx*SLICE +: SLICE] <= s;
         carry <= co;
         idx <= idx + 1'b1;
         if (last) cout_r <= co;
      end
   assign io.in_ready = state == IDLE;
   assign io.out_valid = state == HOLD;
   assign io.sum = sum_r;
   assign io.cout = cout_r;
   assign busy = state != IDLE;
endmodule

// File: tb/tb_add_seq.sv
// tb_add_seq: randomized and directed checks of add_seq against an arithmetic reference
module tb_add_seq;
   localparam int W = 64;
   localparam int NS = 4;
   logic clk = 1'b0, rst = 1'b1, busy;
   int tests = 0, fails = 0;
   add_seq_if #(.WIDTH(W)) io();
   add_seq #(.WIDTH(W), .SLICE(16)) dut(.clk(clk), .rst(rst), .io(io.slave), .busy(busy));
   always #5 clk = ~clk;

   function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
`ifdef ADD_SEQ_SUB_EN
      if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
      return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int stall, input bit glitch);
      logic [W:0] exp;
      int n;
      exp = ref_add(a, b, cin, sub);
      check({tag, "_idle"}, {io.in_ready, busy}, 2'b10);
      io.in_valid = 1'b1; io.a = a; io.b = b; io.cin = cin; io.sub = sub;
      tick();
      io.in_valid = glitch;
      if (glitch) begin
         io.a = {$urandom, $urandom}; io.b = {$urandom, $urandom}; io.cin = ~cin; io.sub = ~sub;
      end
      check({tag, "_calc"}, {io.in_ready, io.out_valid, busy}, 3'b001);
      n = 0;
      do begin
         tick();
         io.in_valid = 1'b0;
         n++;
      end while (!io.out_valid && n < 20);
      check({tag, "_latency"}, n, NS);
      check({tag, "_result"}, {io.cout, io.sum}, exp);
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, "_stall"}, {io.out_valid, io.in_ready, busy, io.cout, io.sum}, {3'b101, exp});
      end
      io.out_ready = 1'b1;
      tick();
      io.out_ready = 1'b0;
      check({tag, "_release"}, {io.out_valid, io.in_ready, busy}, 3'b010);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      io.in_valid = 1'b0; io.a = '0; io.b = '0; io.cin = 1'b0; io.sub = 1'b0; io.out_ready = 1'b0;
      tick(); tick();
      check("reset", {io.in_ready, io.out_valid, busy, io.cout, io.sum}, {3'b100, 1'b0, {W{1'b0}}});
      io.in_valid = 1'b1; io.a = 64'd9;
      tick();
      check("rst_priority", {io.in_ready, busy}, 2'b10);
      io.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      do_op("cross_slice", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 0, 1'b0);
      do_op("chain_cin0", '1, '1, 1'b0, 1'b0, 0, 1'b0);
      do_op("chain_cin1", '1, '1, 1'b1, 1'b0, 0, 1'b0);
      do_op("backpressure", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 5, 1'b0);
      do_op("ignored_in", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 1, 1'b1);
      io.in_valid = 1'b1; io.a = 64'hFFFF_0000_FFFF_0000; io.b = 64'h0001_0000_0001_0000;
      tick();
      io.in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_reset", {io.in_ready, io.out_valid, busy, io.cout, io.sum}, {3'b100, 1'b0, {W{1'b0}}});
      do_op("after_reset", 64'd3, 64'd4, 1'b0, 1'b0, 0, 1'b0);
`ifdef ADD_SEQ_SUB_EN
      do_op("sub_5_7", 64'd5, 64'd7, 1'b0, 1'b1, 0, 1'b0);
      do_op("sub_7_5", 64'd7, 64'd5, 1'b0, 1'b1, 0, 1'b0);
`endif
      for (int k = 0; k < 30; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         if (k % 5 == 0) rb = ~ra;
         do_op("random", ra, rb, 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/add_seq.md
Name: add_seq

Overview:
- Multi-cycle sequencer that performs a WIDTH-bit add using one SLICE-bit ripple-carry slice, reused once per slice.
- Processes the slices from least to most significant, one slice per clock, and registers the carry between slices.
- Sits between an operand producer and a result consumer, with valid/ready on both sides.
- Trades latency (WIDTH/SLICE cycles) for adder area, as an alternative to the full-width structural adder.

Parameters:
- WIDTH, 64, operand and sum width in bits.
- SLICE, 16, width of the shared adder slice. WIDTH must be an integer multiple of SLICE.
- NSLICE, WIDTH/SLICE, derived localparam giving the number of slices (cycles) per operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  addend.
- b  in  WIDTH  addend (subtrahend when sub=1).
- cin  in  1  carry-in to slice 0.
- sub  in  1  subtract request; ignored unless SUB_EN is defined.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the top slice.
- busy  out  1  high in CALC or HOLD.

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, slice index=0, carry register=0.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture a, b and the effective cin into operand registers, set idx=0, go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle, the slice adds a_r[idx*SLICE +: SLICE] + b_r[idx*SLICE +: SLICE] + carry. carry equals the captured cin when idx=0.
  - The slice result is written into sum_r[idx*SLICE +: SLICE]. The slice carry-out is written to the carry register. idx increments.
  - On the edge where idx=NSLICE-1: cout takes the top-slice carry and the state goes to HOLD.
- HOLD:
  - out_valid=1. sum and cout are held stable.
  - On out_ready: out_valid drops and the state goes to IDLE.
  - No input is accepted in the same cycle as the handshake, so the block does not overlap operations.
- Latency: out_valid rises exactly NSLICE clock edges after the accepting edge (4 for the defaults).
- Throughput: at most one operation per NSLICE+2 cycles.
- Outputs:
  - sum and cout are registered.
  - sum is not updated outside CALC.
  - While CALC is in progress, sum holds the previous result in its upper slices and partial new data in its lower slices. Consumers must qualify sum with out_valid.
- Arithmetic: modular WIDTH-bit addition. cout is the true carry out of bit WIDTH-1. Overflow beyond cout is not reported.
- Boundary conditions:
  - in_valid is ignored outside IDLE. Operands are not re-sampled during CALC.
  - out_ready held low stalls indefinitely in HOLD; outputs stay stable.
  - rst asserted in CALC or HOLD: the operation is abandoned, all outputs return to reset values on the next edge, and no result is produced.
  - rst has priority over every handshake in the same cycle.
  - NSLICE=1 is legal: the block does one CALC cycle and then goes to HOLD.

Optional Feature:
- Macro: ADD_SEQ_SUB_EN.
- Defined:
  - When sub=1 at capture, b_r is stored as ~b and the effective cin is 1, so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a >= b unsigned).
  - When sub=0, the block behaves as a plain add.
  - The captured cin port is ignored when sub=1.
- Undefined:
  - The sub input is unused and has no logic behind it. The block is add-only.

Decomposition:
- Package add_seq_pkg holds:
  - the state typedef (IDLE, CALC, HOLD);
  - default WIDTH/SLICE constants;
  - a function computing NSLICE and the index width as clog2(NSLICE), minimum 1.
- One sub-module, add_slice:
  - parameterised SLICE-bit combinational ripple-carry adder;
  - ports: x, y, ci, s, co;
  - instantiated once.
- The FSM, operand, carry and sum registers live in add_seq.

Test Plan:
- Cross-slice carry: a=64'h0000_0000_0000_FFFF, b=1, cin=0 -> after 4 cycles out_valid=1, sum=64'h0000_0000_0001_0000, cout=0.
- Full carry chain: a=b=64'hFFFF_FFFF_FFFF_FFFF, cin=0 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=1. Same operands with cin=1 -> sum=all ones, cout=1.
- Backpressure: complete an add with out_ready=0 for 5 cycles -> out_valid and sum stable and in_ready=0 throughout. Raise out_ready -> next cycle out_valid=0 and in_ready=1.
- Reset mid-operation: accept operands, assert rst on the 2nd CALC cycle -> next edge state=IDLE, out_valid=0, sum=0. A following add of 3+4 gives sum=7.
- Ignored input: pulse in_valid with new operands during CALC -> result still matches the originally accepted operands.
- With ADD_SEQ_SUB_EN, sub=1:
  - a=5, b=7 -> sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0.
  - a=7, b=5 -> sum=2, cout=1.
